// File: rtl/oam_dma_pkg.sv
// Shared constants for the sprite-DMA engine: state encodings and default bus addresses.
package oam_dma_pkg;

  typedef enum logic [2:0] {
    OAM_DMA_ST_IDLE  = 3'd0,
    OAM_DMA_ST_HALT  = 3'd1,
    OAM_DMA_ST_ALIGN = 3'd2,
    OAM_DMA_ST_READ  = 3'd3,
    OAM_DMA_ST_WRITE = 3'd4
  } oam_dma_state_e;

  localparam logic [15:0] OAM_DMA_REG_ADDR_DFLT  = 16'h4014;
  localparam logic [15:0] OAM_DMA_DATA_ADDR_DFLT = 16'h2004;
  localparam int          OAM_DMA_XFER_LEN_DFLT  = 256;

endpackage

// File: rtl/oam_dma.sv
// Sprite-DMA engine between the CPU core and the system bus; copies one page to OAM on a $4014 write.
// Optional parity-alignment cycle is built only when OAM_DMA_ALIGN_EN is defined.
//
// state | meaning
// IDLE  | CPU bus passed through, watching for the trigger write
// HALT  | core frozen, bus shows a read of cpu_addr
// ALIGN | extra halt cycle to land reads on the correct parity
// READ  | read byte {page,idx} into buffer
// WRITE | write buffer to OAM data port, advance idx
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = OAM_DMA_REG_ADDR_DFLT,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DMA_DATA_ADDR_DFLT,
  parameter int          XFER_LEN      = OAM_DMA_XFER_LEN_DFLT
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_rw,
  input  logic [7:0]  bus_data_in,
  output logic [15:0] addr,
  output logic [7:0]  data_out,
  output logic        rw,
  output logic        cpu_halt,
  output logic        dma_active
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  oam_dma_state_e state, state_nxt;
  logic [7:0] idx;
  logic [7:0] page;
  logic [7:0] buffer;
  logic       trigger;

  assign trigger = (cpu_rw == 1'b0) && (cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clock) begin
    if (nreset) begin
      state  <= OAM_DMA_ST_IDLE;
      idx    <= 8'd0;
      page   <= 8'd0;
      buffer <= 8'd0;
    end else begin
      state <= state_nxt;
      // page only latches from IDLE so a retrigger mid-transfer cannot corrupt it
      if (state == OAM_DMA_ST_IDLE && trigger)
        page <= cpu_data_out;
      if (state == OAM_DMA_ST_READ)
        buffer <= bus_data_in;
      if (state == OAM_DMA_ST_WRITE)
        idx <= (idx == LAST_IDX) ? 8'd0 : idx + 8'd1;
    end
  end

`ifdef OAM_DMA_ALIGN_EN
  logic parity;

  always_ff @(posedge clock) begin
    if (nreset)
      parity <= 1'b0;
    else
      parity <= ~parity;
  end
`endif

  always_comb begin
    state_nxt  = state;
    addr       = cpu_addr;
    data_out   = cpu_data_out;
    rw         = cpu_rw;
    cpu_halt   = 1'b1;
    dma_active = 1'b1;
    case (state)
      OAM_DMA_ST_IDLE: begin
        cpu_halt   = 1'b0;
        dma_active = 1'b0;
        if (trigger)
          state_nxt = OAM_DMA_ST_HALT;
      end
      OAM_DMA_ST_HALT: begin
        rw = 1'b1;
`ifdef OAM_DMA_ALIGN_EN
        state_nxt = parity ? OAM_DMA_ST_READ : OAM_DMA_ST_ALIGN;
`else
        state_nxt = OAM_DMA_ST_READ;
`endif
      end
`ifdef OAM_DMA_ALIGN_EN
      OAM_DMA_ST_ALIGN: begin
        rw        = 1'b1;
        state_nxt = OAM_DMA_ST_READ;
      end
`endif
      OAM_DMA_ST_READ: begin
        addr      = {page, idx};
        rw        = 1'b1;
        state_nxt = OAM_DMA_ST_WRITE;
      end
      OAM_DMA_ST_WRITE: begin
        addr      = OAM_DATA_ADDR;
        rw        = 1'b0;
        data_out  = buffer;
        state_nxt = (idx == LAST_IDX) ? OAM_DMA_ST_IDLE : OAM_DMA_ST_READ;
      end
      default: state_nxt = OAM_DMA_ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: scoreboard of expected OAM writes, read addresses and halt lengths.
module tb_oam_dma;

  logic        clock = 1'b0;
  logic        nreset = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data_out = 8'h00;
  logic        cpu_rw = 1'b1;
  logic [7:0]  bus_data_in;
  logic [15:0] addr;
  logic [7:0]  data_out;
  logic        rw;
  logic        cpu_halt;
  logic        dma_active;

  int checks = 0;
  int errors = 0;

  oam_dma dut (
    .clock        (clock),
    .nreset       (nreset),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_rw       (cpu_rw),
    .bus_data_in  (bus_data_in),
    .addr         (addr),
    .data_out     (data_out),
    .rw           (rw),
    .cpu_halt     (cpu_halt),
    .dma_active   (dma_active)
  );

  always #5 clock = ~clock;

  // memory image: page $02 holds i^$A5, other pages differ so a wrong page shows up as bad data
  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ 8'hA5 ^ (a[15:8] ^ 8'h02);
  endfunction

  assign bus_data_in = mem_val(addr);

  logic [7:0]  exp_data_q[$];
  logic [15:0] exp_addr_q[$];
  int          exp_len_q[$];

  // parity of the current cycle, counted from the reset edge
  logic tb_par;
  always @(posedge clock) tb_par <= nreset ? 1'b0 : ~tb_par;

  logic        halt_prev = 1'b0;
  int          halt_len = 0;
  logic [15:0] last_rd = 16'h0000;
  int          wr_count = 0;
  logic        skip_len = 1'b0;

  always @(negedge clock) begin
    logic [7:0]  ed;
    logic [15:0] ea;
    int          el;
    if (dma_active && rw)
      last_rd = addr;
    if (dma_active && !rw) begin
      checks++;
      assert (exp_data_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_write observed addr=%h data=%h expected none", addr, data_out);
      end
      if (exp_data_q.size() > 0) begin
        ed = exp_data_q.pop_front();
        ea = exp_addr_q.pop_front();
        checks++;
        assert (addr === 16'h2004) else begin
          errors++;
          $error("FAIL wr_addr observed %h expected %h", addr, 16'h2004);
        end
        checks++;
        assert (data_out === ed) else begin
          errors++;
          $error("FAIL wr_data observed %h expected %h", data_out, ed);
        end
        checks++;
        assert (last_rd === ea) else begin
          errors++;
          $error("FAIL rd_addr observed %h expected %h", last_rd, ea);
        end
      end
      wr_count++;
    end
    if (cpu_halt)
      halt_len++;
    else if (halt_prev) begin
      if (!skip_len && exp_len_q.size() > 0) begin
        el = exp_len_q.pop_front();
        checks++;
        assert (halt_len === el) else begin
          errors++;
          $error("FAIL halt_len observed %0d expected %0d", halt_len, el);
        end
      end
      halt_len = 0;
    end
    halt_prev = cpu_halt;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // entered and left at posedge+1; want_par is the parity of the HALT cycle
  task automatic trigger(input logic [7:0] page, input logic want_par);
    int len;
    if (tb_par !== ~want_par) begin
      @(posedge clock); #1;
    end
    for (int i = 0; i < 256; i++) begin
      exp_addr_q.push_back({page, 8'(i)});
      exp_data_q.push_back(mem_val({page, 8'(i)}));
    end
    len = 513;
`ifdef OAM_DMA_ALIGN_EN
    if (want_par == 1'b0) len = 514;
`endif
    exp_len_q.push_back(len);
    wr_count = 0;
    cpu_addr = 16'h4014;
    cpu_rw = 1'b0;
    cpu_data_out = page;
    #1;
    chk("trig_bus_addr", addr, 16'h4014);
    chk("trig_bus_rw", {15'd0, rw}, 16'd0);
    chk("trig_halt", {15'd0, cpu_halt}, 16'd0);
    @(posedge clock); #1;
    cpu_addr = 16'h8000;
    cpu_rw = 1'b1;
    cpu_data_out = 8'h00;
    #1;
    chk("halt_cycle_addr", addr, 16'h8000);
    chk("halt_cycle_halt", {14'd0, cpu_halt, dma_active}, 16'd3);
  endtask

  task automatic wait_done();
    int n = 0;
    while (cpu_halt && n < 700) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    assert (n < 700) else begin
      errors++;
      $error("FAIL dma_timeout observed %0d cycles expected under 700", n);
    end
    @(posedge clock); #1;
    chk("queue_empty", 16'(exp_data_q.size()), 16'd0);
    chk("len_queue_empty", 16'(exp_len_q.size()), 16'd0);
  endtask

  initial begin
    int n;
    nreset = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    chk("rst_halt", {14'd0, cpu_halt, dma_active}, 16'd0);
    chk("rst_addr", addr, cpu_addr);
    nreset = 1'b0;
    @(posedge clock); #1;

    // pass-through
    cpu_addr = 16'h8000; cpu_rw = 1'b1; cpu_data_out = 8'h12;
    #1;
    chk("pt_rd_addr", addr, 16'h8000);
    chk("pt_rd_rw", {15'd0, rw}, 16'd1);
    chk("pt_rd_halt", {15'd0, cpu_halt}, 16'd0);
    @(posedge clock); #1;
    cpu_addr = 16'h0300; cpu_rw = 1'b0; cpu_data_out = 8'h55;
    #1;
    chk("pt_wr_addr", addr, 16'h0300);
    chk("pt_wr_data", {8'd0, data_out}, 16'h0055);
    chk("pt_wr_rw", {15'd0, rw}, 16'd0);
    @(posedge clock); #1;
    cpu_addr = 16'h4014; cpu_rw = 1'b1; cpu_data_out = 8'h09;
    @(posedge clock); #1;
    chk("rd_4014_no_trig", {15'd0, cpu_halt}, 16'd0);
    cpu_addr = 16'h8000;

    // full copy, both parities
    trigger(8'h02, 1'b1);
    wait_done();
    trigger(8'h03, 1'b0);
    wait_done();

    // page wrap
    trigger(8'hFF, 1'b1);
    wait_done();
    chk("wrap_last_rd", last_rd, 16'hFFFF);

    // reset mid-transfer after the write of idx $40
    trigger(8'h05, 1'b0);
    n = 0;
    while (wr_count < 65 && n < 800) begin
      @(negedge clock); #1;
      n++;
    end
    chk("mid_wr_count", 16'(wr_count), 16'd65);
    skip_len = 1'b1;
    nreset = 1'b1;
    @(posedge clock); #1;
    chk("mid_rst_halt", {14'd0, cpu_halt, dma_active}, 16'd0);
    exp_data_q.delete();
    exp_addr_q.delete();
    exp_len_q.delete();
    nreset = 1'b0;
    wr_count = 0;
    repeat (10) @(posedge clock);
    #1;
    skip_len = 1'b0;
    chk("no_writes_after_rst", 16'(wr_count), 16'd0);
    trigger(8'h03, 1'b1);
    wait_done();

    // retrigger during WRITE ignored
    trigger(8'h06, 1'b1);
    n = 0;
    while (wr_count < 10 && n < 800) begin
      @(negedge clock); #1;
      n++;
    end
    cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_data_out = 8'h07;
    @(posedge clock); #1;
    @(posedge clock); #1;
    cpu_addr = 16'h8000; cpu_rw = 1'b1; cpu_data_out = 8'h00;
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
